fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and run-control unit for the single-cycle core. It consumes the decoder's branch controls (relative-on-zero, relative-on-nonzero, absolute) and produces the DONE signal that the decoder uses to gate all of its controls. It sits between instruction ROM addressing and the decoder. It also owns start/halt sequencing and a retired-instruction counter used for benchmarking.

Parameters:
PC_W, 10, program counter / instruction ROM address width
OFF_W, 6, width of signed relative branch offset
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  core clock
RESET  input  1  synchronous, active-high reset
START  input  1  single-cycle pulse: begin execution at START_ADDR
START_ADDR  input  PC_W  program entry address
OPCODE  input  4  opcode field of the current instruction (from ROM at PC)
FCODE  input  1  function bit of the current instruction
BRANCH_REL_Z  input  1  decoder control: relative branch if ZERO
BRANCH_REL_NZ  input  1  decoder control: relative branch if not ZERO
BRANCH_ABS  input  1  decoder control: unconditional absolute jump
ZERO  input  1  datapath zero flag for the current instruction
REL_OFFSET  input  OFF_W  signed (two's complement) relative offset
ABS_TARGET  input  PC_W  absolute target (jump LUT / return address)
PC  output  PC_W  current instruction address
DONE  output  1  program halted; held until next START or RESET
RUNNING  output  1  high while in RUN state
INSTR_COUNT  output  CNT_W  instructions retired since last START

Behaviour:
- States: IDLE, RUN, HALTED (encoded in a shared enum).
- RESET (sync, wins over all other inputs, including mid-run): state=IDLE, PC=0, DONE=0, RUNNING=0, INSTR_COUNT=0.
- IDLE: outputs hold. START=1 -> next edge: PC<=START_ADDR, INSTR_COUNT<=0, state=RUN.
- RUN (RUNNING=1): each edge evaluates the instruction currently presented at PC.
  - If {OPCODE,FCODE}==cHALT: state=HALTED, PC holds, INSTR_COUNT +1 (HALT counts as retired). DONE rises on this edge, i.e. registered, visible the cycle after HALT is presented.
  - Else next PC, priority order: BRANCH_ABS -> ABS_TARGET; BRANCH_REL_Z and ZERO -> PC+sext(REL_OFFSET); BRANCH_REL_NZ and !ZERO -> PC+sext(REL_OFFSET); otherwise PC+1. Simultaneous branch controls are illegal from the decoder, but the priority above is normative.
  - All PC arithmetic is modulo 2^PC_W. 2^PC_W-1 +1 wraps to 0; negative offsets wrap below 0.
  - INSTR_COUNT increments once per RUN cycle and saturates at 2^CNT_W-1 (no wrap).
  - START during RUN is ignored.
- HALTED: DONE=1, RUNNING=0, PC and INSTR_COUNT frozen; branch inputs ignored. START=1 -> same action as from IDLE (DONE clears on that edge).
- Latency: a branch decision on cycle n is visible on PC at cycle n+1. No bubbles, one instruction per cycle.
- Outputs are all registered. No combinational path from inputs to outputs.

Decomposition:
- Shared definitions package: cHALT pattern ({4'b1111,1'b1}), state enum (IDLE, RUN, HALTED). Width defaults stay as module parameters.
- One natural sub-module, next_pc_calc: combinational priority mux plus sign-extend add, reused by the future pipelined core.
- Counter and FSM stay in the top level.

Test Plan:
- Reset then START with START_ADDR=0x010, non-branch opcodes for 3 cycles -> PC 0x010, 0x011, 0x012, 0x013; RUNNING=1; INSTR_COUNT=3.
- At PC=0x020: BRANCH_REL_Z=1, ZERO=1, REL_OFFSET=6'h3C (-4) -> PC=0x01C. Repeat with ZERO=0 -> PC=0x021. Repeat for BRANCH_REL_NZ with ZERO=0 -> PC=0x01C.
- PC=0x3FF, no branch -> PC=0x000. PC=0x002, REL_OFFSET=-4, taken -> PC=0x3FE.
- BRANCH_ABS=1 with BRANCH_REL_Z=1, ZERO=1, ABS_TARGET=0x155 -> PC=0x155 (ABS priority).
- HALT presented at PC=0x030 after 5 instructions -> next cycle DONE=1, RUNNING=0, PC=0x030, INSTR_COUNT=6. Frozen for 10 cycles. START with START_ADDR=0 -> DONE=0, PC=0, INSTR_COUNT=0.
- RESET asserted mid-RUN at PC=0x044 -> next cycle PC=0, state IDLE, DONE=0, INSTR_COUNT=0. START asserted in the same cycle as RESET -> still IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: run-control states and the HALT encoding.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  // {OPCODE, FCODE} pattern that retires the program.
  localparam logic [4:0] C_HALT = {4'b1111, 1'b1};

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its decoder/ROM/run-control neighbours.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6,
  parameter int CNT_W = 16
) ();

  logic             START;
  logic [PC_W-1:0]  START_ADDR;
  logic [3:0]       OPCODE;
  logic             FCODE;
  logic             BRANCH_REL_Z;
  logic             BRANCH_REL_NZ;
  logic             BRANCH_ABS;
  logic             ZERO;
  logic [OFF_W-1:0] REL_OFFSET;
  logic [PC_W-1:0]  ABS_TARGET;
  logic [PC_W-1:0]  PC;
  logic             DONE;
  logic             RUNNING;
  logic [CNT_W-1:0] INSTR_COUNT;

  modport slave (
    input  START, START_ADDR, OPCODE, FCODE, BRANCH_REL_Z, BRANCH_REL_NZ,
           BRANCH_ABS, ZERO, REL_OFFSET, ABS_TARGET,
    output PC, DONE, RUNNING, INSTR_COUNT
  );

  modport master (
    output START, START_ADDR, OPCODE, FCODE, BRANCH_REL_Z, BRANCH_REL_NZ,
           BRANCH_ABS, ZERO, REL_OFFSET, ABS_TARGET,
    input  PC, DONE, RUNNING, INSTR_COUNT
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: absolute jump, conditional relative branch, or PC+1.
module fetch_sequencer_next_pc_calc #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6
) (
  input  logic                    [PC_W-1:0]  pc,
  input  logic                                branch_abs,
  input  logic                                branch_rel_z,
  input  logic                                branch_rel_nz,
  input  logic                                zero,
  input  logic signed             [OFF_W-1:0] rel_offset,
  input  logic                    [PC_W-1:0]  abs_target,
  output logic                    [PC_W-1:0]  next_pc
);

  logic signed [PC_W-1:0] off_ext;
  logic        [PC_W-1:0] rel_pc;
  logic        [PC_W-1:0] seq_pc;

  // Sign-extend then add; overflow wraps modulo 2^PC_W in both directions.
  assign off_ext = PC_W'(rel_offset);
  assign rel_pc  = pc + $unsigned(off_ext);
  assign seq_pc  = pc + 1'b1;

  always_comb begin
    next_pc = seq_pc;
    if (branch_abs)
      next_pc = abs_target;
    else if (branch_rel_z && zero)
      next_pc = rel_pc;
    else if (branch_rel_nz && !zero)
      next_pc = rel_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, start/halt run control and saturating retired-instruction counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  fetch_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [PC_W-1:0]  next_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fetch_sequencer_next_pc_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc            (pc_q),
    .branch_abs    (bus.BRANCH_ABS),
    .branch_rel_z  (bus.BRANCH_REL_Z),
    .branch_rel_nz (bus.BRANCH_REL_NZ),
    .zero          (bus.ZERO),
    .rel_offset    (bus.REL_OFFSET),
    .abs_target    (bus.ABS_TARGET),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    running_d = running_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.START) begin
          state_d   = RUN;
          pc_d      = bus.START_ADDR;
          cnt_d     = '0;
          done_d    = 1'b0;
          running_d = 1'b1;
        end
      end
      RUN: begin
        cnt_d = sat_inc(cnt_q);
        // HALT retires but leaves PC pointing at itself.
        if ({bus.OPCODE, bus.FCODE} == C_HALT) begin
          state_d   = HALTED;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else begin
          pc_d = next_pc;
        end
      end
      default: begin
        state_d   = IDLE;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.DONE        = done_q;
  assign bus.RUNNING     = running_q;
  assign bus.INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus halt, reset and saturation sequences.
module tb_fetch_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fetch_sequencer_if #(.PC_W(10), .OFF_W(6), .CNT_W(16)) bus ();
  fetch_sequencer_if #(.PC_W(4),  .OFF_W(3), .CNT_W(3))  bus_s ();

  fetch_sequencer #(.PC_W(10), .OFF_W(6), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  fetch_sequencer #(.PC_W(4), .OFF_W(3), .CNT_W(3)) dut_s (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_s.slave)
  );

  typedef struct {
    logic        start;
    logic [9:0]  addr;
    logic [3:0]  op;
    logic        fc;
    logic        bz;
    logic        bnz;
    logic        babs;
    logic        zero;
    logic [5:0]  off;
    logic [9:0]  abs_t;
    logic [9:0]  e_pc;
    logic        e_done;
    logic        e_run;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[19];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic start, input logic [9:0] addr, input logic [3:0] op,
                       input logic fc, input logic bz, input logic bnz, input logic babs,
                       input logic zero, input logic [5:0] off, input logic [9:0] abs_t);
    bus.START         = start;
    bus.START_ADDR    = addr;
    bus.OPCODE        = op;
    bus.FCODE         = fc;
    bus.BRANCH_REL_Z  = bz;
    bus.BRANCH_REL_NZ = bnz;
    bus.BRANCH_ABS    = babs;
    bus.ZERO          = zero;
    bus.REL_OFFSET    = off;
    bus.ABS_TARGET    = abs_t;
  endtask

  task automatic check_all(input string tag, input logic [9:0] pc, input logic done,
                           input logic run, input logic [15:0] cnt);
    check({tag, ".pc"},   32'(bus.PC),          32'(pc));
    check({tag, ".done"}, 32'(bus.DONE),        32'(done));
    check({tag, ".run"},  32'(bus.RUNNING),     32'(run));
    check({tag, ".cnt"},  32'(bus.INSTR_COUNT), 32'(cnt));
  endtask

  function automatic vec_t mk(input logic start, input logic [9:0] addr, input logic [3:0] op,
                              input logic fc, input logic bz, input logic bnz, input logic babs,
                              input logic zero, input logic [5:0] off, input logic [9:0] abs_t,
                              input logic [9:0] e_pc, input logic [15:0] e_cnt);
    vec_t v;
    v.start = start; v.addr = addr; v.op = op; v.fc = fc;
    v.bz = bz; v.bnz = bnz; v.babs = babs; v.zero = zero;
    v.off = off; v.abs_t = abs_t;
    v.e_pc = e_pc; v.e_done = 1'b0; v.e_run = 1'b1; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    //            st  addr    op    fc bz bnz abs z  off    abs_t   e_pc    cnt
    vt[0]  = mk(1, 10'h010, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h010, 0);
    vt[1]  = mk(0, 10'h000, 4'h1, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h011, 1);
    vt[2]  = mk(0, 10'h000, 4'h2, 1, 0, 0, 0, 1, 6'h00, 10'h000, 10'h012, 2);
    vt[3]  = mk(0, 10'h000, 4'h3, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h013, 3);
    vt[4]  = mk(0, 10'h000, 4'h4, 0, 0, 0, 1, 0, 6'h00, 10'h020, 10'h020, 4);
    vt[5]  = mk(0, 10'h000, 4'h5, 0, 1, 0, 0, 1, 6'h3C, 10'h000, 10'h01C, 5);
    vt[6]  = mk(0, 10'h000, 4'h4, 0, 0, 0, 1, 0, 6'h00, 10'h020, 10'h020, 6);
    vt[7]  = mk(0, 10'h000, 4'h5, 0, 1, 0, 0, 0, 6'h3C, 10'h000, 10'h021, 7);
    vt[8]  = mk(0, 10'h000, 4'h4, 0, 0, 0, 1, 0, 6'h00, 10'h020, 10'h020, 8);
    vt[9]  = mk(0, 10'h000, 4'h6, 0, 0, 1, 0, 0, 6'h3C, 10'h000, 10'h01C, 9);
    vt[10] = mk(0, 10'h000, 4'h6, 0, 0, 1, 0, 1, 6'h3C, 10'h000, 10'h01D, 10);
    vt[11] = mk(0, 10'h000, 4'h4, 0, 0, 0, 1, 0, 6'h00, 10'h3FF, 10'h3FF, 11);
    vt[12] = mk(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h000, 12);
    vt[13] = mk(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h001, 13);
    vt[14] = mk(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h002, 14);
    vt[15] = mk(0, 10'h000, 4'h5, 0, 1, 0, 0, 1, 6'h3C, 10'h000, 10'h3FE, 15);
    vt[16] = mk(0, 10'h000, 4'h7, 0, 1, 0, 1, 1, 6'h3C, 10'h155, 10'h155, 16);
    vt[17] = mk(1, 10'h200, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h156, 17);
    vt[18] = mk(0, 10'h000, 4'hF, 0, 0, 0, 0, 0, 6'h00, 10'h000, 10'h157, 18);

    bus_s.START = 1'b0; bus_s.START_ADDR = '0; bus_s.OPCODE = '0; bus_s.FCODE = 1'b0;
    bus_s.BRANCH_REL_Z = 1'b0; bus_s.BRANCH_REL_NZ = 1'b0; bus_s.BRANCH_ABS = 1'b0;
    bus_s.ZERO = 1'b0; bus_s.REL_OFFSET = '0; bus_s.ABS_TARGET = '0;

    RESET = 1'b1;
    drive(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    step();
    RESET = 1'b0;
    check_all("reset", 10'h000, 1'b0, 1'b0, 16'd0);
    drive(0, 10'h000, 4'h0, 0, 1, 0, 1, 1, 6'h3C, 10'h155);
    step();
    check_all("idle_hold", 10'h000, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].start, vt[i].addr, vt[i].op, vt[i].fc, vt[i].bz, vt[i].bnz,
            vt[i].babs, vt[i].zero, vt[i].off, vt[i].abs_t);
      step();
      check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_done, vt[i].e_run, vt[i].e_cnt);
    end

    // Halt sequence: restart at 0x02B, five instructions reach 0x030, then HALT.
    RESET = 1'b1;
    drive(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    RESET = 1'b0;
    drive(1, 10'h02B, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 10'h000, 4'h1, 0, 0, 0, 0, 0, 6'h00, 10'h000);
      step();
    end
    check_all("pre_halt", 10'h030, 1'b0, 1'b1, 16'd5);
    drive(0, 10'h000, 4'hF, 1, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    check_all("halt", 10'h030, 1'b1, 1'b0, 16'd6);
    for (int i = 0; i < 10; i++) begin
      drive(0, 10'h000, 4'(i), 1'(i), 1'(i >> 1), 1'(i >> 2), 1'(i), 1'b1, 6'h3C, 10'h155);
      step();
      check_all($sformatf("frozen%0d", i), 10'h030, 1'b1, 1'b0, 16'd6);
    end
    drive(1, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    check_all("restart", 10'h000, 1'b0, 1'b1, 16'd0);

    // Reset mid-run at 0x044, then RESET together with START.
    drive(0, 10'h000, 4'h0, 0, 0, 0, 1, 0, 6'h00, 10'h044);
    step();
    check_all("to_044", 10'h044, 1'b0, 1'b1, 16'd1);
    RESET = 1'b1;
    drive(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    check_all("mid_reset", 10'h000, 1'b0, 1'b0, 16'd0);
    drive(1, 10'h123, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    check_all("reset_start", 10'h000, 1'b0, 1'b0, 16'd0);
    RESET = 1'b0;
    drive(0, 10'h000, 4'h0, 0, 0, 0, 0, 0, 6'h00, 10'h000);
    step();
    check_all("post_reset", 10'h000, 1'b0, 1'b0, 16'd0);

    // Counter saturation on the narrow instance (max count 7).
    bus_s.START = 1'b1;
    bus_s.START_ADDR = 4'hC;
    step();
    bus_s.START = 1'b0;
    check("sat.start_pc", 32'(bus_s.PC), 32'h0000000C);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6 || i == 7 || i == 10)
        check($sformatf("sat.cnt%0d", i), 32'(bus_s.INSTR_COUNT), (i > 7) ? 32'd7 : 32'(i));
    end
    check("sat.pc_wrap", 32'(bus_s.PC), 32'h00000006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
